// File: rtl/pipe_control_unit_if.sv
// Signal bundle between the IF/ID register, the pipeline control unit and the
// datapath stage muxes. The control unit drives the slave side.
interface pipe_control_unit_if #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [31:0]      id_insn;
  logic             ex_zero;
  logic             stall_ext;

  logic [5:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             ex_reg_dst;
  logic             ex_ext_sel;
  logic             mem_read;
  logic             mem_write;
  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [REG_W-1:0] wb_wr_reg;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic [1:0]       pc_src;
  logic             illegal_insn;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_insn, ex_zero, stall_ext,
    input  ex_alu_op, ex_alu_src, ex_reg_dst, ex_ext_sel, mem_read, mem_write,
           wb_reg_write, wb_mem_to_reg, wb_wr_reg, pc_write, ifid_write,
           ifid_flush, pc_src, illegal_insn, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_insn, ex_zero, stall_ext,
    output ex_alu_op, ex_alu_src, ex_reg_dst, ex_ext_sel, mem_read, mem_write,
           wb_reg_write, wb_mem_to_reg, wb_wr_reg, pc_write, ifid_write,
           ifid_flush, pc_src, illegal_insn, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined control: decodes IF/ID, carries control bundles through ID/EX,
// EX/MEM and MEM/WB, and handles load-use stalls, branch/jump flushes and counters.
module pipe_control_unit #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input logic                clk,
  input logic                reset,
  pipe_control_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  typedef struct packed {
    logic [5:0]       aluOp;
    logic             aluSrc;
    logic             regDst;
    logic             extSel;
    logic             regWrite;
    logic             memRead;
    logic             memWrite;
    logic             memToReg;
    logic [REG_W-1:0] wrReg;
    logic             isBranch;
    logic             branchNe;
    logic             illegal;
  } idExCtl_t;

  typedef struct packed {
    logic             regWrite;
    logic             memRead;
    logic             memWrite;
    logic             memToReg;
    logic [REG_W-1:0] wrReg;
  } exMemCtl_t;

  typedef struct packed {
    logic             regWrite;
    logic             memToReg;
    logic [REG_W-1:0] wrReg;
  } memWbCtl_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_BRANCH,
    ACT_STALL,
    ACT_JUMP,
    ACT_NORMAL
  } fetchAct_e;

  idExCtl_t         idEx_q, idEx_d;
  exMemCtl_t        exMem_q, exMem_d;
  memWbCtl_t        memWb_q, memWb_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  idExCtl_t         idDec;
  logic             readsRs, readsRt, isJump, hasDest;
  logic             loadUse, branchTaken;
  fetchAct_e        fetchAct;

  logic [5:0]       opcode, funct;
  logic [REG_W-1:0] rsIdx, rtIdx, rdIdx;
  logic             unusedShamt;

  assign opcode      = bus.id_insn[31:26];
  assign funct       = bus.id_insn[5:0];
  assign rsIdx       = REG_W'(bus.id_insn[25:21]);
  assign rtIdx       = REG_W'(bus.id_insn[20:16]);
  assign rdIdx       = REG_W'(bus.id_insn[15:11]);
  assign unusedShamt = ^bus.id_insn[10:6];

  // An invalid IF/ID slot decodes exactly like a nop; writes to r0 are dropped here
  always_comb begin
    idDec   = '0;
    readsRs = 1'b0;
    readsRt = 1'b0;
    isJump  = 1'b0;
    hasDest = 1'b0;
    if (bus.id_valid) begin
      case (opcode)
        OP_RTYPE: begin
          idDec.aluOp    = funct;
          idDec.regDst   = 1'b1;
          idDec.regWrite = 1'b1;
          idDec.extSel   = 1'b1;
          readsRs        = 1'b1;
          readsRt        = 1'b1;
          hasDest        = 1'b1;
        end
        OP_ADDI, OP_ORI: begin
          idDec.aluOp    = (opcode == OP_ADDI) ? 6'b100000 : 6'b100101;
          idDec.aluSrc   = 1'b1;
          idDec.regWrite = 1'b1;
          idDec.extSel   = 1'b1;
          readsRs        = 1'b1;
          hasDest        = 1'b1;
        end
        OP_LW: begin
          idDec.aluSrc   = 1'b1;
          idDec.regWrite = 1'b1;
          idDec.memRead  = 1'b1;
          idDec.memToReg = 1'b1;
          idDec.extSel   = 1'b1;
          readsRs        = 1'b1;
          hasDest        = 1'b1;
        end
        OP_SW: begin
          idDec.aluSrc   = 1'b1;
          idDec.memWrite = 1'b1;
          idDec.extSel   = 1'b1;
          readsRs        = 1'b1;
          readsRt        = 1'b1;
          hasDest        = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          idDec.aluOp    = 6'b100001;
          idDec.isBranch = 1'b1;
          idDec.branchNe = (opcode == OP_BNE);
          idDec.extSel   = 1'b1;
          readsRs        = 1'b1;
          readsRt        = 1'b1;
          hasDest        = 1'b1;
        end
        OP_J: begin
          isJump = 1'b1;
        end
        OP_NOP: begin
        end
        default: begin
          idDec.illegal = 1'b1;
        end
      endcase
    end
    if (hasDest) begin
      idDec.wrReg = idDec.regDst ? rdIdx : rtIdx;
      if (idDec.wrReg == '0) begin
        idDec.regWrite = 1'b0;
      end
    end
  end

  assign branchTaken = idEx_q.isBranch & (bus.ex_zero ^ idEx_q.branchNe);
  assign loadUse     = idEx_q.memRead && (idEx_q.wrReg != '0) &&
                       ((readsRs && (rsIdx == idEx_q.wrReg)) ||
                        (readsRt && (rtIdx == idEx_q.wrReg)));

  // Single priority decision that every fetch output and state update follows
  always_comb begin
    fetchAct = ACT_NORMAL;
    if (reset) begin
      fetchAct = ACT_RESET;
    end else if (bus.stall_ext) begin
      fetchAct = ACT_HOLD;
    end else if (branchTaken) begin
      fetchAct = ACT_BRANCH;
    end else if (loadUse) begin
      fetchAct = ACT_STALL;
    end else if (isJump) begin
      fetchAct = ACT_JUMP;
    end
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ifid_write = 1'b0;
    bus.ifid_flush = 1'b0;
    bus.pc_src     = 2'b00;
    case (fetchAct)
      ACT_BRANCH: begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b1;
        bus.pc_src     = 2'b01;
      end
      ACT_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b1;
        bus.pc_src     = 2'b10;
      end
      ACT_NORMAL: begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Stall, flush and jump all turn the ID instruction into a bubble in EX
  always_comb begin
    idEx_d     = idEx_q;
    exMem_d    = exMem_q;
    memWb_d    = memWb_q;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if ((fetchAct != ACT_RESET) && (fetchAct != ACT_HOLD)) begin
      memWb_d.regWrite = exMem_q.regWrite;
      memWb_d.memToReg = exMem_q.memToReg;
      memWb_d.wrReg    = exMem_q.wrReg;
      exMem_d.regWrite = idEx_q.regWrite;
      exMem_d.memRead  = idEx_q.memRead;
      exMem_d.memWrite = idEx_q.memWrite;
      exMem_d.memToReg = idEx_q.memToReg;
      exMem_d.wrReg    = idEx_q.wrReg;
      idEx_d           = (fetchAct == ACT_NORMAL) ? idDec : '0;
      if ((fetchAct == ACT_STALL) && (stallCnt_q != '1)) begin
        stallCnt_d = stallCnt_q + CNT_W'(1);
      end
      if (((fetchAct == ACT_BRANCH) || (fetchAct == ACT_JUMP)) && (flushCnt_q != '1)) begin
        flushCnt_d = flushCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idEx_q     <= '0;
      exMem_q    <= '0;
      memWb_q    <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      idEx_q     <= idEx_d;
      exMem_q    <= exMem_d;
      memWb_q    <= memWb_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign bus.ex_alu_op     = idEx_q.aluOp;
  assign bus.ex_alu_src    = idEx_q.aluSrc;
  assign bus.ex_reg_dst    = idEx_q.regDst;
  assign bus.ex_ext_sel    = idEx_q.extSel;
  assign bus.illegal_insn  = idEx_q.illegal;
  assign bus.mem_read      = exMem_q.memRead;
  assign bus.mem_write     = exMem_q.memWrite;
  assign bus.wb_reg_write  = memWb_q.regWrite;
  assign bus.wb_mem_to_reg = memWb_q.memToReg;
  assign bus.wb_wr_reg     = memWb_q.wrReg;
  assign bus.stall_cnt     = stallCnt_q;
  assign bus.flush_cnt     = flushCnt_q;

endmodule
